// File: rtl/fsm_table_sequencer_pkg.sv
// Shared widths, table entry field positions and controller mode encoding
// for the table-driven sequencer.
package fsm_table_sequencer_pkg;

    localparam int SYM_W      = 2;
    localparam int ST_W       = 3;
    localparam int OUT_W      = 3;
    localparam int ADDR_W     = SYM_W + ST_W;
    localparam int ENTRY_W    = ST_W + OUT_W;
    localparam int TBL_DEPTH  = 1 << ADDR_W;
    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    localparam int NEXT_HI = 5;
    localparam int NEXT_LO = 3;
    localparam int OUT_HI  = 2;
    localparam int OUT_LO  = 0;

    typedef enum logic {
        MODE_IDLE = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    // Table address: symbol selects the row group, state the row within it.
    function automatic logic [ADDR_W-1:0] tbl_addr(input logic [SYM_W-1:0] sym,
                                                    input logic [ST_W-1:0]  st);
        return {sym, st};
    endfunction

endpackage

// File: rtl/fsm_table_sequencer_if.sv
// Control, configuration, symbol stream and status bundle of the sequencer.
interface fsm_table_sequencer_if;
    import fsm_table_sequencer_pkg::*;

    logic                 cfg_we;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [ENTRY_W-1:0]   cfg_data;
    logic                 start;
    logic                 stop;
    logic                 clear;
    logic [SYM_W-1:0]     sym_in;
    logic                 sym_valid;
    logic                 sym_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic [ST_W-1:0]      cur_state;
    logic                 running;
    logic [LVL_W-1:0]     fifo_level;
    logic                 overflow;
    logic                 cfg_err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop, clear, sym_in, sym_valid,
        output sym_ready, out_data, out_valid, cur_state, running, fifo_level,
               overflow, cfg_err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop, clear, sym_in, sym_valid,
        input  sym_ready, out_data, out_valid, cur_state, running, fifo_level,
               overflow, cfg_err
    );

endinterface

// File: rtl/fsm_table_sequencer_sym_fifo.sv
// Symbol FIFO with exact occupancy count and a sticky overflow flag.
// Full is judged on the pre-edge level, so a push while full is always dropped.
module sym_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (level_q == LVL_W'(DEPTH));
    assign empty_s   = (level_q == {LVL_W{1'b0}});
    assign push_ok_s = push_i && !full_s;
    assign pop_ok_s  = pop_i && !empty_s;

    // Pointer, level and sticky overflow state; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (push_i && full_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o     = mem_q[rd_ptr_q];
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/fsm_table_sequencer.sv
// Run controller for a table-driven 8-state machine: owns the transition
// table and symbol FIFO, steps one transition per queued symbol while in RUN.
module fsm_table_sequencer
    import fsm_table_sequencer_pkg::*;
#(
    parameter int              DEPTH       = FIFO_DEPTH,
    parameter logic [ST_W-1:0] RESET_STATE = 3'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    fsm_table_sequencer_if.slave    seq_if
);

    mode_e              mode_q;
    mode_e              mode_d;
    logic [ST_W-1:0]    cur_state_q;
    logic [ST_W-1:0]    cur_state_d;
    logic [OUT_W-1:0]   out_data_q;
    logic [OUT_W-1:0]   out_data_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               cfg_err_q;
    logic               cfg_err_d;
    logic [ENTRY_W-1:0] table_q [TBL_DEPTH];

    logic [SYM_W-1:0]   fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LVL_W-1:0]   fifo_level_s;
    logic               fifo_overflow_s;
    logic               step_s;
    logic               tbl_we_s;
    logic [ENTRY_W-1:0] entry_s;

    // stop has priority over a step so the cycle that requests IDLE never consumes a symbol.
    assign step_s   = (mode_q == MODE_RUN) && !fifo_empty_s && !seq_if.stop;
    assign tbl_we_s = seq_if.cfg_we && (mode_q == MODE_IDLE);
    assign entry_s  = table_q[tbl_addr(fifo_dout_s, cur_state_q)];

    sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SYM_W)
    ) u_sym_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (seq_if.sym_valid),
        .pop_i      (step_s),
        .din_i      (seq_if.sym_in),
        .dout_o     (fifo_dout_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s),
        .level_o    (fifo_level_s),
        .overflow_o (fifo_overflow_s)
    );

    // Transition table storage, contents survive reset.
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            table_q[seq_if.cfg_addr] <= seq_if.cfg_data;
        end
    end

    // Controller mode and step/status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_IDLE;
            cur_state_q <= RESET_STATE;
            out_data_q  <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            cur_state_q <= cur_state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Mode next-state logic.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_IDLE: begin
                if (seq_if.stop) begin
                    mode_d = MODE_IDLE;
                end else if (seq_if.start) begin
                    mode_d = MODE_RUN;
                end else begin
                    mode_d = MODE_IDLE;
                end
            end
            MODE_RUN: begin
                if (seq_if.stop) begin
                    mode_d = MODE_IDLE;
                end else begin
                    mode_d = MODE_RUN;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    // Machine step, clear and sticky config-error logic.
    always_comb begin
        cur_state_d = cur_state_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        cfg_err_d   = cfg_err_q;
        if (step_s) begin
            cur_state_d = entry_s[NEXT_HI:NEXT_LO];
            out_data_d  = entry_s[OUT_HI:OUT_LO];
            out_valid_d = 1'b1;
        end else if ((mode_q == MODE_IDLE) && seq_if.clear) begin
            cur_state_d = RESET_STATE;
        end else begin
            cur_state_d = cur_state_q;
        end
        if (seq_if.cfg_we && (mode_q == MODE_RUN)) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = cfg_err_q;
        end
    end

    assign seq_if.sym_ready  = !fifo_full_s;
    assign seq_if.out_data   = out_data_q;
    assign seq_if.out_valid  = out_valid_q;
    assign seq_if.cur_state  = cur_state_q;
    assign seq_if.running    = (mode_q == MODE_RUN);
    assign seq_if.fifo_level = fifo_level_s;
    assign seq_if.overflow   = fifo_overflow_s;
    assign seq_if.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Directed self-checking bench for fsm_table_sequencer.
module tb_fsm_table_sequencer;
    import fsm_table_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [2:0] seen[$];

    fsm_table_sequencer_if bus ();

    fsm_table_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .seq_if (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference machine: out field equals next state.
    function automatic logic [2:0] std_next(input int s, input int q);
        case (q)
            0: return 3'd1;
            1: return (s == 2) ? 3'd3 : 3'd2;
            2: case (s)
                   0: return 3'd0;
                   1: return 3'd4;
                   2: return 3'd7;
                   default: return 3'd4;
               endcase
            3: return (s == 3) ? 3'd5 : 3'd2;
            4: return 3'd3;
            5: return 3'd6;
            6: return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    task automatic push_sym(input logic [1:0] s);
        bus.sym_in = s;
        bus.sym_valid = 1'b1;
        tick();
        bus.sym_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic collect(input int cycles);
        seen.delete();
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen.push_back(bus.out_data);
        end
    endtask

    task automatic check_seq(input string name, input logic [2:0] exp[$]);
        tests++;
        if (seen.size() !== exp.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d pulses, expected %0d", name, seen.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests++;
                if (seen[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL %s_out%0d: got %0d expected %0d", name, i, seen[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = 5'd0; bus.cfg_data = 6'd0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
        bus.sym_in = 2'd0; bus.sym_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cur_state", int'(bus.cur_state), 0);
        check_val("rst_out_valid", int'(bus.out_valid), 0);
        check_val("rst_out_data", int'(bus.out_data), 0);
        check_val("rst_level", int'(bus.fifo_level), 0);
        check_val("rst_running", int'(bus.running), 0);
        check_val("rst_sym_ready", int'(bus.sym_ready), 1);
        check_val("rst_flags", int'({bus.overflow, bus.cfg_err}), 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_program();
        for (int q = 0; q < 8; q++) begin
            for (int s = 0; s < 4; s++) begin
                bus.cfg_we = 1'b1;
                bus.cfg_addr = {2'(s), 3'(q)};
                bus.cfg_data = {std_next(s, q), std_next(s, q)};
                tick();
            end
        end
        bus.cfg_we = 1'b0;
        push_sym(2'd1); push_sym(2'd1); push_sym(2'd2); push_sym(2'd2);
        check_val("prog_level", int'(bus.fifo_level), 4);
        pulse_start();
        collect(8);
        check_seq("prog", '{3'd1, 3'd2, 3'd7, 3'd1});
        check_val("prog_final_state", int'(bus.cur_state), 1);
        pulse_stop();
    endtask

    task automatic test_backpressure();
        pulse_clear();
        for (int i = 0; i < 16; i++) push_sym(2'd0);
        check_val("bp_ready_full", int'(bus.sym_ready), 0);
        check_val("bp_level_full", int'(bus.fifo_level), 16);
        check_val("bp_no_ovf_yet", int'(bus.overflow), 0);
        push_sym(2'd3);
        check_val("bp_overflow", int'(bus.overflow), 1);
        check_val("bp_level_after_drop", int'(bus.fifo_level), 16);
        pulse_start();
        collect(24);
        check_val("bp_pulse_count", seen.size(), 16);
        check_val("bp_level_drained", int'(bus.fifo_level), 0);
        pulse_stop();
    endtask

    task automatic test_stop_clear();
        pulse_clear();
        push_sym(2'd1); push_sym(2'd1); push_sym(2'd2); push_sym(2'd2);
        pulse_start();
        tick();
        tick();
        pulse_stop();
        check_val("sc_running", int'(bus.running), 0);
        check_val("sc_state_after_stop", int'(bus.cur_state), 2);
        check_val("sc_level_after_stop", int'(bus.fifo_level), 2);
        pulse_clear();
        check_val("sc_state_after_clear", int'(bus.cur_state), 0);
        check_val("sc_level_after_clear", int'(bus.fifo_level), 2);
        pulse_start();
        collect(6);
        check_seq("sc_resume", '{3'd1, 3'd3});
        check_val("sc_final_state", int'(bus.cur_state), 3);
    endtask

    task automatic test_cfg_lockout();
        check_val("lk_running", int'(bus.running), 1);
        check_val("lk_err_before", int'(bus.cfg_err), 0);
        bus.clear = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd0; bus.cfg_data = 6'o77;
        tick();
        bus.cfg_we = 1'b0;
        bus.clear = 1'b0;
        check_val("lk_cfg_err", int'(bus.cfg_err), 1);
        check_val("lk_clear_ignored", int'(bus.cur_state), 3);
        pulse_stop();
        pulse_clear();
        push_sym(2'd0);
        pulse_start();
        collect(4);
        check_seq("lk_entry_kept", '{3'd1});
        pulse_stop();
    endtask

    task automatic test_simultaneous();
        pulse_clear();
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check_val("sim_start_stop", int'(bus.running), 0);
        for (int i = 0; i < 5; i++) push_sym(2'd0);
        check_val("sim_level5", int'(bus.fifo_level), 5);
        pulse_start();
        check_val("sim_level_after_start", int'(bus.fifo_level), 5);
        bus.sym_in = 2'd0;
        bus.sym_valid = 1'b1;
        tick();
        bus.sym_valid = 1'b0;
        check_val("sim_push_pop", int'(bus.fifo_level), 5);
        collect(10);
        check_val("sim_drained", int'(bus.fifo_level), 0);
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        push_sym(2'd0); push_sym(2'd0); push_sym(2'd0);
        pulse_start();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_cur_state", int'(bus.cur_state), 0);
        check_val("mid_out_valid", int'(bus.out_valid), 0);
        check_val("mid_level", int'(bus.fifo_level), 0);
        check_val("mid_running", int'(bus.running), 0);
        check_val("mid_flags", int'({bus.overflow, bus.cfg_err}), 0);
        tick();
        reset = 1'b0;
        tick();
        push_sym(2'd2); push_sym(2'd2);
        pulse_start();
        collect(6);
        check_seq("mid_table_kept", '{3'd1, 3'd3});
        pulse_stop();
    endtask

    initial begin
        test_reset();
        test_program();
        test_backpressure();
        test_stop_clear();
        test_cfg_lockout();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
